// File: rtl/maria_pkg.sv
// Shared MARIA register-file definitions: register offsets, reset constants
// and the WSYNC state encoding.
package maria_pkg;

    localparam logic [4:0] OFF_BG       = 5'h00;
    localparam logic [4:0] OFF_WSYNC    = 5'h04;
    localparam logic [4:0] OFF_MSTAT    = 5'h08;
    localparam logic [4:0] OFF_ZPH      = 5'h0C;
    localparam logic [4:0] OFF_ZPL      = 5'h10;
    localparam logic [4:0] OFF_CHARBASE = 5'h14;
    localparam logic [4:0] OFF_CTRL     = 5'h1C;

    localparam logic [7:0]  CTRL_RST = 8'h70;
    localparam logic [15:0] DPP_NTSC = 16'h0084;
    localparam logic [15:0] DPP_PAL  = 16'h2730;

    typedef enum logic {
        WS_RUN  = 1'b0,
        WS_HOLD = 1'b1
    } wsync_state_e;

endpackage

// File: rtl/maria_regfile_if.sv
// CPU-side bus of the MARIA register window: strobe, select, direction,
// offset and data in both directions.
interface maria_regfile_if;
    logic       bus_en;
    logic       cs_maria;
    logic       we_b;
    logic [4:0] addr;
    logic [7:0] db_in;
    logic [7:0] db_out;

    modport master (
        output bus_en, cs_maria, we_b, addr, db_in,
        input  db_out
    );

    modport slave (
        input  bus_en, cs_maria, we_b, addr, db_in,
        output db_out
    );
endinterface

// File: rtl/maria_wsync.sv
// WSYNC halt FSM: a WSYNC write stalls the CPU (ready=0) until the next
// end-of-scanline strobe.
module maria_wsync
    import maria_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wsync_wr,
    input  logic line_end,
    output logic ready
);

    wsync_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WS_RUN;
        else     state_q <= state_d;
    end

    // A WSYNC write always wins over a coincident line_end.
    always_comb begin
        state_d = state_q;
        ready   = 1'b1;
        case (state_q)
            WS_RUN: begin
                if (wsync_wr) state_d = WS_HOLD;
            end
            WS_HOLD: begin
                ready = 1'b0;
                if (line_end && !wsync_wr) state_d = WS_RUN;
            end
            default: state_d = WS_RUN;
        endcase
    end

endmodule

// File: rtl/maria_regfile.sv
// MARIA CPU register file: palettes, CTRL, CHARBASE, ZP staging/DPP, MSTAT read.
// Define MARIA_READBACK_EN to make stored registers readable.
module maria_regfile
    import maria_pkg::*;
#(
    parameter int unsigned PALETTES = 8,
    parameter int unsigned PAL      = 0
) (
    input  logic                        sysclock,
    input  logic                        reset,
    maria_regfile_if.slave              bus,
    input  logic [7:0]                  status_in,
    input  logic                        line_end,
    input  logic                        frame_start,
    output logic                        ready,
    output logic [7:0]                  ctrl,
    output logic [7:0]                  char_base,
    output logic [15:0]                 dpp,
    output logic [3*PALETTES:0][7:0]    color_map,
    output logic [1:0]                  zp_pending
);

    localparam logic [15:0] DPP_RST = (PAL == 1) ? DPP_PAL : DPP_NTSC;

    logic [7:0]               ctrl_q, ctrl_d, cb_q, cb_d, db_out_q, db_out_d;
    logic [7:0]               zph_q, zph_d, zpl_q, zpl_d, rd_val;
    logic [15:0]              dpp_q, dpp_d;
    logic [1:0]               pend_q, pend_d;
    logic [3*PALETTES:0][7:0] cmap_q, cmap_d;
    logic                     wr, rd, is_col;
    logic [4:0]               cmap_idx;

    assign wr     = bus.bus_en & bus.cs_maria & ~bus.we_b;
    assign rd     = bus.bus_en & bus.cs_maria &  bus.we_b;
    assign is_col = (bus.addr[1:0] != 2'b00);
    // Offset 4p+c+1 maps to entry 1+3p+c, i.e. 3p + addr[1:0].
    assign cmap_idx = ({2'b00, bus.addr[4:2]} << 1) + {2'b00, bus.addr[4:2]}
                    + {3'b000, bus.addr[1:0]};

    always_comb begin
        rd_val = '0;
        if (bus.addr == OFF_MSTAT) begin
            rd_val = status_in;
        end
`ifdef MARIA_READBACK_EN
        else if (is_col) begin
            for (int unsigned i = 1; i <= 3 * PALETTES; i++) begin
                if (cmap_idx == 5'(i)) rd_val = cmap_q[i];
            end
        end else begin
            case (bus.addr)
                OFF_BG:       rd_val = cmap_q[0];
                OFF_ZPH:      rd_val = zph_q;
                OFF_ZPL:      rd_val = zpl_q;
                OFF_CHARBASE: rd_val = cb_q;
                OFF_CTRL:     rd_val = ctrl_q;
                default:      rd_val = '0;
            endcase
        end
`endif
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        cb_d     = cb_q;
        cmap_d   = cmap_q;
        zph_d    = zph_q;
        zpl_d    = zpl_q;
        db_out_d = rd ? rd_val : db_out_q;
        // DPP takes the pre-write staged value; a coincident ZP write re-arms its pending bit.
        dpp_d    = frame_start ? {zph_q, zpl_q} : dpp_q;
        pend_d   = frame_start ? 2'b00 : pend_q;
        if (wr) begin
            if (is_col) begin
                for (int unsigned i = 1; i <= 3 * PALETTES; i++) begin
                    if (cmap_idx == 5'(i)) cmap_d[i] = bus.db_in;
                end
            end else begin
                case (bus.addr)
                    OFF_BG:       cmap_d[0] = bus.db_in;
                    OFF_ZPH:      begin zph_d = bus.db_in; pend_d[1] = 1'b1; end
                    OFF_ZPL:      begin zpl_d = bus.db_in; pend_d[0] = 1'b1; end
                    OFF_CHARBASE: cb_d = bus.db_in;
                    OFF_CTRL:     ctrl_d = bus.db_in;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            ctrl_q   <= CTRL_RST;
            cb_q     <= '0;
            cmap_q   <= '0;
            db_out_q <= '0;
            zph_q    <= DPP_RST[15:8];
            zpl_q    <= DPP_RST[7:0];
            dpp_q    <= DPP_RST;
            pend_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            cb_q     <= cb_d;
            cmap_q   <= cmap_d;
            db_out_q <= db_out_d;
            zph_q    <= zph_d;
            zpl_q    <= zpl_d;
            dpp_q    <= dpp_d;
            pend_q   <= pend_d;
        end
    end

    maria_wsync u_wsync (
        .clk      (sysclock),
        .rst      (reset),
        .wsync_wr (wr && (bus.addr == OFF_WSYNC)),
        .line_end (line_end),
        .ready    (ready)
    );

    assign bus.db_out = db_out_q;
    assign ctrl       = ctrl_q;
    assign char_base  = cb_q;
    assign dpp        = dpp_q;
    assign color_map  = cmap_q;
    assign zp_pending = pend_q;

endmodule

// File: tb/tb_maria_regfile.sv
// Bench for maria_regfile: two instances (8 palettes NTSC, 2 palettes PAL)
// driven in lockstep and checked against a register-level reference model.
module tb_maria_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       t_en, t_cs, t_we;
    logic [4:0] t_addr;
    logic [7:0] t_din, status;
    logic       line_end, frame_start;

    maria_regfile_if bus_a ();
    maria_regfile_if bus_b ();
    assign bus_a.bus_en = t_en;   assign bus_b.bus_en = t_en;
    assign bus_a.cs_maria = t_cs; assign bus_b.cs_maria = t_cs;
    assign bus_a.we_b = t_we;     assign bus_b.we_b = t_we;
    assign bus_a.addr = t_addr;   assign bus_b.addr = t_addr;
    assign bus_a.db_in = t_din;   assign bus_b.db_in = t_din;

    logic             ready_a, ready_b;
    logic [7:0]       ctrl_a, ctrl_b, cb_a, cb_b;
    logic [15:0]      dpp_a, dpp_b;
    logic [1:0]       pend_a, pend_b;
    logic [24:0][7:0] cmap_a;
    logic [6:0][7:0]  cmap_b;

    maria_regfile #(.PALETTES(8), .PAL(0)) dut_a (
        .sysclock(clk), .reset(rst), .bus(bus_a.slave), .status_in(status),
        .line_end(line_end), .frame_start(frame_start), .ready(ready_a),
        .ctrl(ctrl_a), .char_base(cb_a), .dpp(dpp_a), .color_map(cmap_a),
        .zp_pending(pend_a));

    maria_regfile #(.PALETTES(2), .PAL(1)) dut_b (
        .sysclock(clk), .reset(rst), .bus(bus_b.slave), .status_in(status),
        .line_end(line_end), .frame_start(frame_start), .ready(ready_b),
        .ctrl(ctrl_b), .char_base(cb_b), .dpp(dpp_b), .color_map(cmap_b),
        .zp_pending(pend_b));

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int unsigned npal [2] = '{8, 2};
    logic [7:0]  m_cmap [2][25];
    logic [7:0]  m_ctrl [2], m_cb [2], m_zph [2], m_zpl [2], m_db [2];
    logic [15:0] m_dpp [2];
    logic [1:0]  m_pend [2];
    logic        m_ready [2];

    function automatic logic d_ready(int unsigned k); return k == 0 ? ready_a : ready_b; endfunction
    function automatic logic [7:0] d_ctrl(int unsigned k); return k == 0 ? ctrl_a : ctrl_b; endfunction
    function automatic logic [7:0] d_cb(int unsigned k); return k == 0 ? cb_a : cb_b; endfunction
    function automatic logic [15:0] d_dpp(int unsigned k); return k == 0 ? dpp_a : dpp_b; endfunction
    function automatic logic [1:0] d_pend(int unsigned k); return k == 0 ? pend_a : pend_b; endfunction
    function automatic logic [7:0] d_db(int unsigned k); return k == 0 ? bus_a.db_out : bus_b.db_out; endfunction
    function automatic logic [7:0] d_cmap(int unsigned k, int unsigned i);
        logic [4:0] ia;
        logic [2:0] ib;
        ia = i[4:0];
        ib = i[2:0];
        if (k == 0) return cmap_a[ia];
        return cmap_b[ib];
    endfunction

    task automatic model_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            m_dpp[k]   = (k == 0) ? 16'h0084 : 16'h2730;
            m_zph[k]   = m_dpp[k][15:8];
            m_zpl[k]   = m_dpp[k][7:0];
            m_ctrl[k]  = 8'h70;
            m_cb[k]    = 8'h00;
            m_db[k]    = 8'h00;
            m_pend[k]  = 2'b00;
            m_ready[k] = 1'b1;
            for (int unsigned i = 0; i < 25; i++) m_cmap[k][i] = 8'h00;
        end
    endtask

    task automatic model_step();
        logic wr, rd;
        int unsigned off, p, c;
        wr  = t_en && t_cs && !t_we;
        rd  = t_en && t_cs && t_we;
        off = int'(t_addr);
        p   = off / 4;
        c   = off % 4;
        for (int unsigned k = 0; k < 2; k++) begin
            if (rd) begin
                m_db[k] = 8'h00;
                if (off == 8) m_db[k] = status;
`ifdef MARIA_READBACK_EN
                else if (c != 0) begin
                    if (p < npal[k]) m_db[k] = m_cmap[k][1 + 3 * p + c - 1];
                end
                else if (off == 0)  m_db[k] = m_cmap[k][0];
                else if (off == 12) m_db[k] = m_zph[k];
                else if (off == 16) m_db[k] = m_zpl[k];
                else if (off == 20) m_db[k] = m_cb[k];
                else if (off == 28) m_db[k] = m_ctrl[k];
`endif
            end
            if (frame_start) begin
                m_dpp[k]  = {m_zph[k], m_zpl[k]};
                m_pend[k] = 2'b00;
            end
            if (wr) begin
                if (c != 0) begin
                    if (p < npal[k]) m_cmap[k][1 + 3 * p + c - 1] = t_din;
                end
                else if (off == 0)  m_cmap[k][0] = t_din;
                else if (off == 12) begin m_zph[k] = t_din; m_pend[k][1] = 1'b1; end
                else if (off == 16) begin m_zpl[k] = t_din; m_pend[k][0] = 1'b1; end
                else if (off == 20) m_cb[k] = t_din;
                else if (off == 28) m_ctrl[k] = t_din;
            end
            if (wr && off == 4)  m_ready[k] = 1'b0;
            else if (line_end)   m_ready[k] = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [4:0] a, input logic [7:0] d);
        t_en = en; t_cs = 1'b1; t_we = we; t_addr = a; t_din = d;
    endtask

    task automatic idle();
        t_en = 1'b0; t_cs = 1'b0; t_we = 1'b1; t_addr = '0; t_din = '0;
        line_end = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b/%b want 1/1", ready_a, ready_b); end
        n_vec++; if (ctrl_a !== 8'h70 || ctrl_b !== 8'h70) begin n_err++; $display("FAIL reset_ctrl got %h/%h want 70", ctrl_a, ctrl_b); end
        n_vec++; if (dpp_a !== 16'h0084) begin n_err++; $display("FAIL reset_dpp_ntsc got %h want 0084", dpp_a); end
        n_vec++; if (dpp_b !== 16'h2730) begin n_err++; $display("FAIL reset_dpp_pal got %h want 2730", dpp_b); end
        n_vec++; if (pend_a !== 2'b00 || cb_a !== 8'h00 || bus_a.db_out !== 8'h00 || cmap_a !== '0)
            begin n_err++; $display("FAIL reset_misc pend %b cb %h db %h cmap0 %h want zeros", pend_a, cb_a, bus_a.db_out, cmap_a[0]); end
    endtask

    task automatic test_palette();
        logic [6:0][7:0] snap_b;
        drive(1'b1, 1'b0, 5'h06, 8'h1A); tick(); idle();
        n_vec++; if (cmap_a[5] !== 8'h1A) begin n_err++; $display("FAIL pal_p1c1_a got %h want 1a", cmap_a[5]); end
        n_vec++; if (cmap_b[5] !== 8'h1A) begin n_err++; $display("FAIL pal_p1c1_b got %h want 1a", cmap_b[5]); end
        snap_b = cmap_b;
        drive(1'b1, 1'b0, 5'h0D, 8'h55); tick(); idle();
        n_vec++; if (cmap_b !== snap_b || pend_b !== 2'b00 || ctrl_b !== 8'h70)
            begin n_err++; $display("FAIL pal_ignored_b cmap %h want %h", cmap_b, snap_b); end
        n_vec++; if (cmap_a[10] !== 8'h55) begin n_err++; $display("FAIL pal_p3c0_a got %h want 55", cmap_a[10]); end
    endtask

    task automatic test_wsync();
        drive(1'b1, 1'b0, 5'h04, 8'h00); tick(); idle();
        n_vec++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin n_err++; $display("FAIL wsync_hold got %b/%b want 0", ready_a, ready_b); end
        repeat (9) begin
            tick();
            n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL wsync_stay got %b want 0", ready_a); end
        end
        line_end = 1'b1; tick(); idle();
        n_vec++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin n_err++; $display("FAIL wsync_release got %b/%b want 1", ready_a, ready_b); end
        drive(1'b1, 1'b0, 5'h04, 8'h00); line_end = 1'b1; tick(); idle();
        n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL wsync_coincident got %b want 0", ready_a); end
        repeat (3) tick();
        drive(1'b1, 1'b0, 5'h04, 8'h00); tick(); idle();
        n_vec++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin n_err++; $display("FAIL wsync_rewrite got %b/%b want 0", ready_a, ready_b); end
        line_end = 1'b1; tick(); idle();
        n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL wsync_release2 got %b want 1", ready_a); end
    endtask

    task automatic test_zp();
        drive(1'b1, 1'b0, 5'h0C, 8'h12); tick();
        drive(1'b1, 1'b0, 5'h10, 8'h34); tick(); idle();
        n_vec++; if (pend_a !== 2'b11 || pend_b !== 2'b11) begin n_err++; $display("FAIL zp_pending got %b/%b want 11", pend_a, pend_b); end
        n_vec++; if (dpp_a !== 16'h0084 || dpp_b !== 16'h2730) begin n_err++; $display("FAIL zp_dpp_hold got %h/%h want 0084/2730", dpp_a, dpp_b); end
        frame_start = 1'b1; tick(); idle();
        n_vec++; if (dpp_a !== 16'h1234 || dpp_b !== 16'h1234 || pend_a !== 2'b00)
            begin n_err++; $display("FAIL zp_frame got %h/%h pend %b want 1234 00", dpp_a, dpp_b, pend_a); end
        drive(1'b1, 1'b0, 5'h10, 8'h56); frame_start = 1'b1; tick(); idle();
        n_vec++; if (dpp_a !== 16'h1234 || pend_a !== 2'b01) begin n_err++; $display("FAIL zp_coincident got %h pend %b want 1234 01", dpp_a, pend_a); end
        frame_start = 1'b1; tick(); idle();
        n_vec++; if (dpp_a !== 16'h1256 || pend_a !== 2'b00) begin n_err++; $display("FAIL zp_frame2 got %h pend %b want 1256 00", dpp_a, pend_a); end
    endtask

    task automatic test_read();
        logic [7:0] exp_ctrl;
        status = 8'h80; drive(1'b1, 1'b1, 5'h08, 8'h00); tick(); idle();
        n_vec++; if (bus_a.db_out !== 8'h80 || bus_b.db_out !== 8'h80) begin n_err++; $display("FAIL rd_mstat got %h/%h want 80", bus_a.db_out, bus_b.db_out); end
        status = 8'h11; tick();
        n_vec++; if (bus_a.db_out !== 8'h80) begin n_err++; $display("FAIL rd_hold got %h want 80", bus_a.db_out); end
        drive(1'b1, 1'b0, 5'h1C, 8'h43); tick(); idle();
        n_vec++; if (ctrl_a !== 8'h43) begin n_err++; $display("FAIL wr_ctrl got %h want 43", ctrl_a); end
        drive(1'b1, 1'b1, 5'h1C, 8'h00); tick(); idle();
`ifdef MARIA_READBACK_EN
        exp_ctrl = 8'h43;
`else
        exp_ctrl = 8'h00;
`endif
        n_vec++; if (bus_a.db_out !== exp_ctrl) begin n_err++; $display("FAIL rd_ctrl got %h want %h", bus_a.db_out, exp_ctrl); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 5'h04, 8'h00); tick(); idle();
        n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL arst_prehold got %b want 0", ready_a); end
        rst = 1'b1;
        #1;
        n_vec++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b/%b want 1", ready_a, ready_b); end
        n_vec++; if (ctrl_a !== 8'h70 || dpp_a !== 16'h0084 || dpp_b !== 16'h2730 || cmap_a !== '0 || pend_a !== 2'b00)
            begin n_err++; $display("FAIL arst_regs ctrl %h dpp %h/%h pend %b want 70 0084/2730 00", ctrl_a, dpp_a, dpp_b, pend_a); end
        model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic test_random();
        for (int unsigned n = 0; n < 400; n++) begin
            t_en = ($urandom_range(0, 3) != 0);
            t_cs = ($urandom_range(0, 4) != 0);
            t_we = $urandom_range(0, 1) != 0;
            t_addr = 5'($urandom_range(0, 31));
            t_din = 8'($urandom);
            status = 8'($urandom);
            line_end = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 11) == 0);
            tick();
            for (int unsigned k = 0; k < 2; k++) begin
                n_vec++; if (d_ready(k) !== m_ready[k]) begin n_err++; $display("FAIL rnd_ready dut%0d cyc %0d got %b want %b", k, n, d_ready(k), m_ready[k]); end
                n_vec++; if (d_ctrl(k) !== m_ctrl[k] || d_cb(k) !== m_cb[k])
                    begin n_err++; $display("FAIL rnd_ctrl_cb dut%0d cyc %0d got %h %h want %h %h", k, n, d_ctrl(k), d_cb(k), m_ctrl[k], m_cb[k]); end
                n_vec++; if (d_dpp(k) !== m_dpp[k] || d_pend(k) !== m_pend[k])
                    begin n_err++; $display("FAIL rnd_dpp dut%0d cyc %0d got %h %b want %h %b", k, n, d_dpp(k), d_pend(k), m_dpp[k], m_pend[k]); end
                n_vec++; if (d_db(k) !== m_db[k]) begin n_err++; $display("FAIL rnd_db dut%0d cyc %0d got %h want %h", k, n, d_db(k), m_db[k]); end
                for (int unsigned i = 0; i <= 3 * npal[k]; i++) begin
                    n_vec++; if (d_cmap(k, i) !== m_cmap[k][i])
                        begin n_err++; $display("FAIL rnd_cmap dut%0d cyc %0d entry %0d got %h want %h", k, n, i, d_cmap(k, i), m_cmap[k][i]); end
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        status = 8'h00;
        model_reset();
        #12 rst = 1'b0;
        test_reset();
        test_palette();
        test_wsync();
        test_zp();
        test_read();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maria_regfile.md
MARIA_REGFILE -- requirements
Module: maria_regfile

Interface
REQ-001 SHALL have parameter PALETTES, default 8, meaning the number of colour palettes implemented (legal range 1..8).
REQ-002 SHALL have parameter PAL, default 0, meaning the display list pointer reset value is PAL (1) or NTSC (0).
REQ-003 SHALL have port sysclock, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port bus_en, input, 1 bit: CPU bus-cycle strobe (pclk0 qualifier); all bus actions occur only when it is high.
REQ-006 SHALL have port cs_maria, input, 1 bit: MARIA register window selected.
REQ-007 SHALL have port we_b, input, 1 bit: 0 = write, 1 = read.
REQ-008 SHALL have port addr, input, 5 bits: register offset (AB[4:0]); all mirrors fold onto it.
REQ-009 SHALL have port db_in, input, 8 bits: write data.
REQ-010 SHALL have port db_out, output, 8 bits: registered read data.
REQ-011 SHALL have port status_in, input, 8 bits: MSTAT value.
REQ-012 SHALL have port line_end, input, 1 bit: one-cycle end-of-scanline strobe.
REQ-013 SHALL have port frame_start, input, 1 bit: one-cycle start-of-frame strobe.
REQ-014 SHALL have port ready, output, 1 bit: CPU RDY.
REQ-015 SHALL have ports ctrl (8 bits), char_base (8 bits) and dpp (16 bits), all outputs.
REQ-016 SHALL have port color_map, output, (1+3*PALETTES)x8 bits: entry 0 is background; entry 1+3p+c is palette p, colour c.
REQ-017 SHALL have port zp_pending, output, 2 bits: [1] = ZPH staged, [0] = ZPL staged.

Function
REQ-018 A write SHALL occur when bus_en & cs_maria & ~we_b, and a read when bus_en & cs_maria & we_b.
REQ-019 Offset map SHALL be: 0x00 background; 4p+c+1 (c = 0..2) palette p colour c; 0x04 WSYNC; 0x08 MSTAT (read-only); 0x0C ZPH; 0x10 ZPL; 0x14 CHARBASE; 0x1C CTRL; 0x18 ignored.
REQ-020 Writes to palettes p >= PALETTES SHALL be ignored, with no state change.
REQ-021 Every register update and db_out update SHALL take effect on the sysclock edge that samples the qualifying cycle (1-cycle latency).
REQ-022 On a read, db_out SHALL load status_in at 0x08 and 0x00 at all other offsets; db_out SHALL hold when no read occurs.
REQ-023 The WSYNC FSM SHALL have the states RUN (ready=1) and HOLD (ready=0).
REQ-024 RUN SHALL go to HOLD on a write to 0x04.
REQ-025 HOLD SHALL go to RUN on line_end.
REQ-026 A WSYNC write and line_end in the same cycle SHALL result in HOLD, released by the next line_end.
REQ-027 A WSYNC write while in HOLD SHALL keep the FSM in HOLD.
REQ-028 ZPH and ZPL writes SHALL load staging registers and set zp_pending[1] or zp_pending[0] respectively.
REQ-029 On frame_start, dpp SHALL load {ZPH_stage, ZPL_stage} and zp_pending SHALL clear.
REQ-030 On a simultaneous ZP write and frame_start, dpp SHALL load the pre-write staged value, the new byte SHALL be staged, and its pending bit SHALL remain set.
REQ-031 frame_start SHALL update dpp even when zp_pending is 00.

Reset
REQ-032 Reset SHALL set ctrl=0x70 (DMA off), char_base=0x00, all color_map entries=0x00, db_out=0x00, zp_pending=00, FSM=RUN (ready=1).
REQ-033 Reset SHALL set the staging registers and dpp to 0x2730 if PAL=1, else 0x0084.
REQ-034 Reset asserted mid-HOLD SHALL force ready=1 immediately (asynchronously).

Configuration
REQ-035 With MARIA_READBACK_EN defined, reads of colour, CTRL, CHARBASE, ZPH and ZPL offsets SHALL return the stored or staged value; MSTAT behaviour SHALL be unchanged.
REQ-036 Without MARIA_READBACK_EN, those reads SHALL return 0x00, matching hardware.

Structure
REQ-037 Package maria_pkg SHALL hold the register offset localparams, the ctrl reset constant, the NTSC/PAL dpp constants and the WSYNC state enum.
REQ-038 Sub-module maria_wsync SHALL contain the WSYNC FSM; all other logic SHALL be flat.

Verification
REQ-039 Reset with PAL=0 -> ready=1, ctrl=0x70, dpp=0x0084; with PAL=1 -> dpp=0x2730.
REQ-040 Write 0x1A to offset 0x06 (p1c1) -> color_map[5]=0x1A next cycle; with PALETTES=2, write to 0x0D (p3c0) -> no change anywhere.
REQ-041 WSYNC write -> ready=0 next cycle; line_end 10 cycles later -> ready=1; WSYNC write and line_end together -> ready stays 0 until the following line_end.
REQ-042 Write ZPH=0x12 and ZPL=0x34 -> zp_pending=11, dpp unchanged; frame_start -> dpp=0x1234, zp_pending=00.
REQ-043 Read 0x08 with status_in=0x80 -> db_out=0x80; read 0x1C after writing ctrl=0x43 -> 0x00, or 0x43 with MARIA_READBACK_EN.
REQ-044 Assert reset during HOLD -> ready=1 before the next sysclock edge, all registers at reset values.
